clk_divider_multi: RTL and testbench



---
 rtl/clk_divider_multi.sv | 151 +++++++++++++++
 tb/tb_clk_divider_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// ---------------------------------------------------------------------------
// clk_divider_multi
//
// N_CH independent programmable divided-clock / tick generators running in
// the clk_in domain. Each channel has its own period (div) and high time
// (high). New settings are written into a shadow copy and only take effect
// at a period boundary, when the channel is disabled, or on resync, so the
// outputs never glitch. The div_clk outputs are plain registers: nothing is
// gated or muxed in their path.
//
// Ports:
//   clk_in    system clock
//   rst       asynchronous, active-high reset
//   en        per-channel run enable (level)
//   cfg_we    one-cycle config write strobe
//   cfg_ch    channel targeted by the write
//   cfg_div   new period in clk_in cycles (>= 2)
//   cfg_high  new high time in clk_in cycles (1 .. cfg_div-1)
//   resync    one-cycle pulse restarting all channels in phase
//   div_clk   divided clock per channel, registered
//   tick      one-cycle strobe in the last cycle of each period, registered
//   cfg_err   one-cycle pulse when a write is rejected
// ---------------------------------------------------------------------------
module clk_divider_multi #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_DIV  = 100000000,
    parameter int DEFAULT_HIGH = 50000000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic              resync,
    output logic [N_CH-1:0]   div_clk,
    output logic [N_CH-1:0]   tick,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);

    logic wr_ok_s;

    // Write validation: channel in range, period >= 2, 1 <= high < period.
    always_comb begin
        wr_ok_s = 1'b0;
        if (({1'b0, cfg_ch} < (CH_W+1)'(N_CH)) &&
            (cfg_div >= CNT_W'(2)) &&
            (cfg_high != CNT_W'(0)) &&
            (cfg_high < cfg_div)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Rejected-write pulse.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~wr_ok_s;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] div_act_r;
        logic [CNT_W-1:0] high_act_r;
        logic [CNT_W-1:0] div_sh_r;
        logic [CNT_W-1:0] high_sh_r;
        logic             pend_r;
        logic             clk_r;
        logic             tick_r;
        logic             wrap_s;
        logic             load_s;
        logic             idle_s;

        // Last cycle of the period; cnt never exceeds div_act-1.
        assign wrap_s = (cnt_r == (div_act_r - CNT_W'(1)));
        assign load_s = cfg_we & wr_ok_s & (cfg_ch == CH_W'(g));
        // resync overrides en: both hold the channel at period start.
        assign idle_s = resync | ~en[g];

        // Channel counter, active config and registered outputs.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt_r      <= CNT_W'(0);
                div_act_r  <= DIV_RST;
                high_act_r <= HIGH_RST;
                clk_r      <= 1'b0;
                tick_r     <= 1'b0;
            end else if (idle_s) begin
                cnt_r  <= CNT_W'(0);
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
                // A config written before this edge takes effect right away.
                if (pend_r) begin
                    div_act_r  <= div_sh_r;
                    high_act_r <= high_sh_r;
                end else begin
                    div_act_r  <= div_act_r;
                    high_act_r <= high_act_r;
                end
            end else begin
                // Outputs are computed from the pre-update count.
                clk_r  <= (cnt_r < high_act_r);
                tick_r <= wrap_s;
                if (wrap_s) begin
                    cnt_r <= CNT_W'(0);
                    if (pend_r) begin
                        div_act_r  <= div_sh_r;
                        high_act_r <= high_sh_r;
                    end else begin
                        div_act_r  <= div_act_r;
                        high_act_r <= high_act_r;
                    end
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end

        // Shadow config and pending flag. A write on the same edge as an
        // apply sets pending again, so it waits for the next boundary.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                div_sh_r  <= DIV_RST;
                high_sh_r <= HIGH_RST;
                pend_r    <= 1'b0;
            end else if (load_s) begin
                div_sh_r  <= cfg_div;
                high_sh_r <= cfg_high;
                pend_r    <= 1'b1;
            end else if (idle_s || wrap_s) begin
                pend_r    <= 1'b0;
            end else begin
                pend_r    <= pend_r;
            end
        end

        assign div_clk[g] = clk_r;
        assign tick[g]    = tick_r;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
module tb_clk_divider_multi;
    localparam int N_CH     = 2;
    localparam int CNT_W    = 8;
    localparam int DEF_DIV  = 10;
    localparam int DEF_HIGH = 5;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   en;
    logic              cfg_we;
    logic [0:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic              resync;
    logic [N_CH-1:0]   div_clk;
    logic [N_CH-1:0]   tick;
    logic              cfg_err;

    clk_divider_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV), .DEFAULT_HIGH(DEF_HIGH)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .resync(resync),
        .div_clk(div_clk), .tick(tick), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: each channel is described by its settings and the
    // edge number (t0) at which its current period began; position within
    // the period is simply cyc - t0.
    int               m_div  [N_CH];
    int               m_high [N_CH];
    int               s_div  [N_CH];
    int               s_high [N_CH];
    bit               m_pend [N_CH];
    int               t0     [N_CH];
    logic [N_CH-1:0]  e_clk;
    logic [N_CH-1:0]  e_tick;
    logic             e_err;

    task automatic model_reset(input int start);
        for (int i = 0; i < N_CH; i++) begin
            m_div[i] = DEF_DIV;  m_high[i] = DEF_HIGH;
            s_div[i] = DEF_DIV;  s_high[i] = DEF_HIGH;
            m_pend[i] = 1'b0;    t0[i] = start;
        end
        e_clk = '0; e_tick = '0; e_err = 1'b0;
    endtask

    task automatic model_apply(input int i);
        if (m_pend[i]) begin
            m_div[i] = s_div[i]; m_high[i] = s_high[i]; m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ok;
        int pos;
        if (rst) begin
            model_reset(cyc + 1);
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            pos = cyc - t0[i];
            if (resync || !en[i]) begin
                e_clk[i] = 1'b0; e_tick[i] = 1'b0; t0[i] = cyc + 1;
                model_apply(i);
            end else begin
                e_clk[i]  = (pos < m_high[i]);
                e_tick[i] = (pos == m_div[i] - 1);
                if (pos == m_div[i] - 1) begin
                    t0[i] = cyc + 1;
                    model_apply(i);
                end
            end
        end
        ok = (int'(cfg_ch) < N_CH) && (int'(cfg_div) >= 2) &&
             (int'(cfg_high) >= 1) && (int'(cfg_high) <= int'(cfg_div) - 1);
        if (cfg_we && ok) begin
            s_div[cfg_ch] = cfg_div; s_high[cfg_ch] = cfg_high; m_pend[cfg_ch] = 1'b1;
        end
        e_err = cfg_we && !ok;
    endtask

    // One clock edge: update the model with the inputs the DUT sees, then
    // step 1 ns past the edge so outputs are sampled away from it.
    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_ch = 1'b0; cfg_div = '0; cfg_high = '0; resync = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if ({div_clk, tick, cfg_err} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=00000", cyc, {div_clk, tick, cfg_err});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_defaults();
        int highs0, ticks1;
        highs0 = 0; ticks1 = 0;
        en = 2'b11;
        for (int k = 0; k < 20; k++) begin
            cycle();
            highs0 += div_clk[0];
            ticks1 += tick[1];
            checks++;
            if (div_clk !== e_clk) begin
                errors++; $display("FAIL defaults_div_clk cyc=%0d got=%b exp=%b", cyc, div_clk, e_clk);
            end
            checks++;
            if (tick !== e_tick) begin
                errors++; $display("FAIL defaults_tick cyc=%0d got=%b exp=%b", cyc, tick, e_tick);
            end
            checks++;
            if (div_clk[0] !== div_clk[1]) begin
                errors++; $display("FAIL defaults_ch_equal cyc=%0d got=%b exp=equal bits", cyc, div_clk);
            end
        end
        checks++;
        if (highs0 != 10) begin
            errors++; $display("FAIL defaults_high_count got=%0d exp=10", highs0);
        end
        checks++;
        if (ticks1 != 2) begin
            errors++; $display("FAIL defaults_tick_count got=%0d exp=2", ticks1);
        end
    endtask

    task automatic test_cfg_midperiod();
        int guard;
        guard = 0;
        while ((cyc - t0[0]) != 3 && guard < 20) begin
            cycle(); guard++;
        end
        checks++;
        if ((cyc - t0[0]) != 3) begin
            errors++; $display("FAIL midperiod_reach got=%0d exp=3", cyc - t0[0]);
        end
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4; cfg_high = 8'd1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            idle_inputs();
            checks++;
            if ({div_clk, tick, cfg_err} !== {e_clk, e_tick, e_err}) begin
                errors++;
                $display("FAIL midperiod cyc=%0d got=%b exp=%b", cyc, {div_clk, tick, cfg_err}, {e_clk, e_tick, e_err});
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] tbl_div  [3] = '{8'd1, 8'd5, 8'd6};
        logic [7:0] tbl_high [3] = '{8'd1, 8'd0, 8'd6};
        for (int w = 0; w < 3; w++) begin
            cfg_we = 1'b1; cfg_ch = w[0]; cfg_div = tbl_div[w]; cfg_high = tbl_high[w];
            cycle();
            idle_inputs();
            checks++;
            if (cfg_err !== 1'b1) begin
                errors++; $display("FAIL invalid_err_pulse w=%0d got=%b exp=1", w, cfg_err);
            end
            for (int k = 0; k < 4; k++) begin
                cycle();
                checks++;
                if ({div_clk, tick, cfg_err} !== {e_clk, e_tick, 1'b0}) begin
                    errors++;
                    $display("FAIL invalid_after cyc=%0d got=%b exp=%b", cyc, {div_clk, tick, cfg_err}, {e_clk, e_tick, 1'b0});
                end
            end
        end
    endtask

    task automatic test_disable();
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd6; cfg_high = 8'd3;
        cycle();
        idle_inputs();
        cycle();
        en[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if ({div_clk[1], tick[1]} !== 2'b00) begin
                errors++; $display("FAIL disabled_outputs cyc=%0d got=%b exp=00", cyc, {div_clk[1], tick[1]});
            end
        end
        en[1] = 1'b1;
        cycle();
        checks++;
        if (div_clk[1] !== 1'b1) begin
            errors++; $display("FAIL reenable_first_high got=%b exp=1", div_clk[1]);
        end
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if ({div_clk, tick} !== {e_clk, e_tick}) begin
                errors++; $display("FAIL reenable cyc=%0d got=%b exp=%b", cyc, {div_clk, tick}, {e_clk, e_tick});
            end
        end
    endtask

    task automatic test_resync();
        resync = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd8; cfg_high = 8'd2;
        cycle();
        idle_inputs();
        checks++;
        if ({div_clk, tick} !== 4'b0000) begin
            errors++; $display("FAIL resync_zero got=%b exp=0000", {div_clk, tick});
        end
        cycle();
        checks++;
        if (div_clk !== 2'b11) begin
            errors++; $display("FAIL resync_aligned got=%b exp=11", div_clk);
        end
        for (int k = 0; k < 30; k++) begin
            cycle();
            checks++;
            if ({div_clk, tick, cfg_err} !== {e_clk, e_tick, e_err}) begin
                errors++;
                $display("FAIL resync_run cyc=%0d got=%b exp=%b", cyc, {div_clk, tick, cfg_err}, {e_clk, e_tick, e_err});
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3; cfg_high = 8'd1;
        cycle();
        idle_inputs();
        guard = 0;
        while (e_clk[0] !== 1'b1 && guard < 20) begin
            cycle(); guard++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({div_clk, tick, cfg_err} !== 5'b0) begin
            errors++; $display("FAIL async_reset got=%b exp=00000", {div_clk, tick, cfg_err});
        end
        model_reset(cyc);
        cycle();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            checks++;
            if ({div_clk, tick} !== {e_clk, e_tick}) begin
                errors++; $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, {div_clk, tick}, {e_clk, e_tick});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            idle_inputs();
            if ($urandom_range(0, 9) == 0) en[$urandom_range(0, 1)] = ~en[$urandom_range(0, 1)];
            if ($urandom_range(0, 15) == 0) en = 2'b11;
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1'b1; cfg_ch = 1'($urandom_range(0, 1));
                cfg_div = 8'($urandom_range(0, 12)); cfg_high = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 40) == 0) resync = 1'b1;
            cycle();
            checks++;
            if ({div_clk, tick, cfg_err} !== {e_clk, e_tick, e_err}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {div_clk, tick, cfg_err}, {e_clk, e_tick, e_err});
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1; en = '0;
        idle_inputs();
        model_reset(0);
        #1;
        test_reset();
        test_defaults();
        test_cfg_midperiod();
        test_invalid();
        test_disable();
        test_resync();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
